cook_timer: RTL and testbench
=============================

// Module: cook_timer
// PURPOSE
//   Microwave cook-time register and countdown, four BCD digits MM:SS.
//   Digits are keyed in while the magnetron is off. The time counts down once per second while magnetron_on is high.
//   Drives timer_done into the magnetron set/reset logic, directly upstream of it.
//   Also drives a one-cycle done_pulse to the beeper/display stage.
// PARAMETERS
//   TICKS_PER_SEC  1000  clk cycles per second of countdown (>=2); prescaler width = $clog2(TICKS_PER_SEC)
// PORTS
//   clk           in   1  single system clock, rising edge
//   resetn        in   1  asynchronous active-low reset
//   clearn        in   1  synchronous active-low clear of time and prescaler
//   key_valid     in   1  one-cycle strobe: key_digit is valid
//   key_digit     in   4  BCD digit 0-9; values 10-15 are ignored
//   magnetron_on  in   1  magnetron latch output; high = cooking, count enabled
//   min_tens      out  4  BCD minutes tens
//   min_ones      out  4  BCD minutes ones
//   sec_tens      out  4  BCD seconds tens (0-9 on entry; 0-5 after first borrow)
//   sec_ones      out  4  BCD seconds ones
//   timer_done    out  1  high when all four digits are 0 (registered)
//   done_pulse    out  1  one-cycle high when countdown expires
// BEHAVIOUR
//   Reset (resetn=0, async)
//   - all digits = 0, prescaler = 0, state IDLE, timer_done = 1, done_pulse = 0.
//   - timer_done=1 out of reset keeps the magnetron from starting with no time set.
//   State machine
//   - IDLE: time == 0.
//   - READY: time != 0 and magnetron_on = 0.
//   - RUN: time != 0 and magnetron_on = 1.
//   Priority each cycle: clearn low > key entry > countdown.
//   Clear (clearn=0)
//   - digits = 0, prescaler = 0, go to IDLE, no done_pulse.
//   - Applies in every state, including RUN.
//   Key entry
//   - Accepted only when key_valid = 1, key_digit <= 9 and magnetron_on = 0.
//   - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
//   - The old min_tens is discarded.
//   - Any key entry resets the prescaler to 0.
//   - Keys while magnetron_on = 1 are ignored.
//   Countdown (RUN only)
//   - Prescaler increments each cycle.
//   - When it equals TICKS_PER_SEC-1 it wraps to 0, and the same edge decrements the time by 1 s.
//   - Seconds: ones>0: ones-1. ones=0, tens>0: ones=9, tens-1. Both 0: borrow a minute, seconds=59.
//   - Minutes: same BCD rule on min_ones/min_tens. Borrow never occurs at 00:00 (RUN requires nonzero time).
//   - Entered seconds above 59 (e.g. 00:90) count down as 90 s, linearly.
//   Pause
//   - magnetron_on = 0 in RUN goes to READY.
//   - Prescaler and digits hold, so the partial second is kept on resume.
//   Expiry
//   - The decrement that yields 00:00 moves to IDLE.
//   - timer_done = 1 and done_pulse = 1 on the cycle after that edge (both registered from the new time).
//   - done_pulse lasts exactly one cycle.
//   - Prescaler is reset to 0 on expiry.
//   timer_done
//   - Registered; equals (next digits == 0).
//   - Never glitches between edges and never depends on inputs combinationally.
//   Edge cases
//   - magnetron_on = 1 while IDLE: no counting, prescaler stays 0, timer_done stays 1.
//   - Async reset mid-RUN: immediate return to the reset values above.
// TESTING (TICKS_PER_SEC=4)
//   1 Reset, then keys 1,3,0 -> digits 01:30, timer_done=0, state READY.
//   2 Time 00:02, magnetron_on=1 -> 00:01 after 4 clk, 00:00 after 8 clk, done_pulse exactly 1 cycle, timer_done=1.
//   3 Time 01:00, run 4 clk -> 00:59. Time 00:90, run 4 clk -> 00:89.
//   4 Run 00:05 for 2 clk, drop magnetron_on 10 clk, raise it -> decrement 2 clk after resume. key 7 during RUN is ignored.
//   5 Running 00:30, clearn=0 one cycle -> 00:00, timer_done=1, done_pulse stays 0. Same cycle key_valid=1: key is ignored.
//   6 Keys 1,2,3,4,5 -> 23:45. key_digit=12 -> no change. resetn=0 mid-RUN -> all outputs at reset values at once.

Source files
------------

// File: rtl/cook_timer.sv
// cook_timer: microwave MM:SS BCD cook-time entry register and once-per-second countdown.
// Ports:
//   clk, resetn (async active-low), clearn (sync active-low clear)
//   key_valid/key_digit: keypad strobe and BCD digit, shifted in from the right
//   magnetron_on: cooking enable from the magnetron latch
//   min_tens/min_ones/sec_tens/sec_ones: current time digits
//   timer_done: registered "time is 00:00"; done_pulse: one cycle at countdown expiry
module cook_timer #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       magnetron_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  typedef enum logic [1:0] {IDLE, READY, RUN} state_t;
  state_t state;
  logic [PW-1:0] pre, pre_n;
  logic [15:0] tm, nxt, dec_t;
  logic key_ok, run, dec, s_b;
  assign tm = {min_tens, min_ones, sec_tens, sec_ones};
  assign key_ok = key_valid && key_digit <= 4'd9 && !magnetron_on;
  // state != IDLE mirrors "time is nonzero", so counting starts on the first cycle magnetron_on is seen
  assign run = magnetron_on && state != IDLE;
  assign s_b = sec_ones == 4'd0 && sec_tens == 4'd0;
  always_comb begin
    dec_t[3:0]   = sec_ones != 4'd0 ? sec_ones - 4'd1 : 4'd9;
    dec_t[7:4]   = sec_ones != 4'd0 ? sec_tens : (sec_tens != 4'd0 ? sec_tens - 4'd1 : 4'd5);
    dec_t[11:8]  = s_b ? (min_ones != 4'd0 ? min_ones - 4'd1 : 4'd9) : min_ones;
    dec_t[15:12] = s_b && min_ones == 4'd0 ? min_tens - 4'd1 : min_tens;
  end
  always_comb begin
    nxt = tm;
    pre_n = pre;
    dec = 1'b0;
    if (!clearn) begin
      nxt = '0;
      pre_n = '0;
    end else if (key_ok) begin
      nxt = {tm[11:0], key_digit};
      pre_n = '0;
    end else if (run) begin
      dec = pre == PW'(TICKS_PER_SEC - 1);
      pre_n = dec ? '0 : pre + PW'(1);
      nxt = dec ? dec_t : tm;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= '0;
      pre <= '0;
      state <= IDLE;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      {min_tens, min_ones, sec_tens, sec_ones} <= nxt;
      pre <= pre_n;
      state <= nxt == '0 ? IDLE : (magnetron_on ? RUN : READY);
      timer_done <= nxt == '0;
      done_pulse <= dec && nxt == '0;
    end
  end
endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed self-checking bench for cook_timer with TICKS_PER_SEC=4.
module tb_cook_timer;
  logic clk = 1'b0, resetn = 1'b0, clearn = 1'b1, key_valid = 1'b0, magnetron_on = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic timer_done, done_pulse;
  logic [15:0] tm;
  int errors = 0, checks = 0;

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .key_valid(key_valid),
    .key_digit(key_digit), .magnetron_on(magnetron_on),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;
  assign tm = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic clear();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: time=%h done=%b pulse=%b, required 0000 1 0", tm, timer_done, done_pulse);
    end
    resetn = 1'b1;
    cyc(1);
    key(1); key(3); key(0);
    checks++;
    if (tm !== 16'h0130 || timer_done !== 1'b0) begin
      errors++;
      $display("FAIL entry_0130: time=%h done=%b, required 0130 0", tm, timer_done);
    end
  endtask

  task automatic test_expiry();
    clear();
    key(0); key(2);
    magnetron_on = 1'b1;
    cyc(3);
    checks++;
    if (tm !== 16'h0002) begin errors++; $display("FAIL run_3clk: time=%h, required 0002", tm); end
    cyc(1);
    checks++;
    if (tm !== 16'h0001 || timer_done !== 1'b0) begin
      errors++; $display("FAIL run_4clk: time=%h done=%b, required 0001 0", tm, timer_done);
    end
    cyc(4);
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b1) begin
      errors++; $display("FAIL expire: time=%h done=%b pulse=%b, required 0000 1 1", tm, timer_done, done_pulse);
    end
    cyc(1);
    checks++;
    if (done_pulse !== 1'b0 || timer_done !== 1'b1) begin
      errors++; $display("FAIL pulse_width: pulse=%b done=%b, required 0 1", done_pulse, timer_done);
    end
    cyc(6);
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++; $display("FAIL idle_on: time=%h done=%b pulse=%b, required 0000 1 0", tm, timer_done, done_pulse);
    end
    magnetron_on = 1'b0;
  endtask

  task automatic test_borrow();
    clear();
    key(1); key(0); key(0);
    magnetron_on = 1'b1;
    cyc(4);
    magnetron_on = 1'b0;
    checks++;
    if (tm !== 16'h0059) begin errors++; $display("FAIL borrow_0100: time=%h, required 0059", tm); end
    clear();
    key(9); key(0);
    magnetron_on = 1'b1;
    cyc(4);
    magnetron_on = 1'b0;
    checks++;
    if (tm !== 16'h0089) begin errors++; $display("FAIL linear_0090: time=%h, required 0089", tm); end
    clear();
    key(1); key(0); key(0); key(0);
    magnetron_on = 1'b1;
    cyc(4);
    magnetron_on = 1'b0;
    checks++;
    if (tm !== 16'h0959) begin errors++; $display("FAIL borrow_1000: time=%h, required 0959", tm); end
  endtask

  task automatic test_pause();
    clear();
    key(5);
    magnetron_on = 1'b1;
    cyc(2);
    magnetron_on = 1'b0;
    cyc(10);
    checks++;
    if (tm !== 16'h0005 || timer_done !== 1'b0) begin
      errors++; $display("FAIL pause_hold: time=%h done=%b, required 0005 0", tm, timer_done);
    end
    magnetron_on = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd7;
    cyc(1);
    key_valid = 1'b0;
    checks++;
    if (tm !== 16'h0005) begin errors++; $display("FAIL resume_1clk_key7: time=%h, required 0005", tm); end
    cyc(1);
    checks++;
    if (tm !== 16'h0004) begin errors++; $display("FAIL resume_2clk: time=%h, required 0004", tm); end
    magnetron_on = 1'b0;
  endtask

  task automatic test_clear();
    clear();
    key(3); key(0);
    magnetron_on = 1'b1;
    cyc(2);
    clearn = 1'b0;
    key_valid = 1'b1;
    key_digit = 4'd4;
    cyc(1);
    clearn = 1'b1;
    key_valid = 1'b0;
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++; $display("FAIL clear_run: time=%h done=%b pulse=%b, required 0000 1 0", tm, timer_done, done_pulse);
    end
    cyc(1);
    checks++;
    if (done_pulse !== 1'b0 || tm !== 16'h0000) begin
      errors++; $display("FAIL clear_no_pulse: time=%h pulse=%b, required 0000 0", tm, done_pulse);
    end
    magnetron_on = 1'b0;
    key(2);
    clearn = 1'b0;
    key(4);
    clearn = 1'b1;
    checks++;
    if (tm !== 16'h0000) begin errors++; $display("FAIL clear_over_key: time=%h, required 0000", tm); end
  endtask

  task automatic test_back_to_back();
    clear();
    key(1); key(2); key(3); key(4); key(5);
    checks++;
    if (tm !== 16'h2345) begin errors++; $display("FAIL shift_5keys: time=%h, required 2345", tm); end
    key(4'd12);
    checks++;
    if (tm !== 16'h2345) begin errors++; $display("FAIL bad_digit: time=%h, required 2345", tm); end
    magnetron_on = 1'b1;
    cyc(2);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++; $display("FAIL async_reset: time=%h done=%b pulse=%b, required 0000 1 0", tm, timer_done, done_pulse);
    end
    cyc(2);
    magnetron_on = 1'b0;
    resetn = 1'b1;
    cyc(1);
    checks++;
    if (tm !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL after_reset: time=%h done=%b, required 0000 1", tm, timer_done);
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
